// File: rtl/uart_ctl_rx.sv
// rtl/uart_ctl_rx.sv - 8N1 UART receiver with '1'/'2' command decoder
//
// Deserialises 8N1 frames from uart_rx. Each completed byte goes into a one-entry buffer.
// The decoder then takes it from the buffer. ASCII CMD_INCR / CMD_DECR bytes raise a
// next/previous command on a valid/ready handshake. All other bytes are consumed and
// dropped.
//
// Ports:
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   uart_rx    in   1  serial line, idle high, asynchronous to clk
//   rx_data    out  8  last byte taken by the decoder
//   rx_strobe  out  1  one-cycle pulse, aligned with rx_data update
//   ctl_valid  out  1  command pending, held until accepted
//   ctl_ready  in   1  consumer accept (with ctl_valid)
//   ctl_incr   out  1  pending command is increment
//   ctl_decr   out  1  pending command is decrement

module uart_ctl_rx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  CMD_INCR     = 8'h31,
  parameter logic [7:0]  CMD_DECR     = 8'h32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       ctl_valid,
  input  logic       ctl_ready,
  output logic       ctl_incr,
  output logic       ctl_decr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Synchroniser and one extra stage of history for falling-edge detection.
  // All stages reset to 1 so a reset never looks like a start edge.
  logic rx_s1, rx_sync, rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  // Receiver FSM
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            done_n;
  logic            frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) begin
          state_n = S_START;
        end
      end
      S_START: begin
        // Half-bit check rejects short low glitches on an idle line.
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_sync) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Framing error: hold off until the line returns high so the
        // low stop bit is not mistaken for the next start edge.
        cnt_n = '0;
        if (rx_sync) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // One-entry byte buffer. A frame finishing while the buffer is still
  // occupied is dropped, even if the buffer is being drained that cycle.
  logic       byte_valid;
  logic [7:0] byte_buf;
  logic       take;
  logic       fire;

  assign take = byte_valid && !ctl_valid;
  assign fire = ctl_valid && ctl_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_valid <= 1'b0;
      byte_buf   <= '0;
    end else if (frame_done && !byte_valid) begin
      byte_valid <= 1'b1;
      byte_buf   <= shift;
    end else if (take) begin
      byte_valid <= 1'b0;
    end
  end

  // Decoder and command register. take needs !ctl_valid, fire needs
  // ctl_valid, so a byte can only be consumed the cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_strobe <= 1'b0;
      ctl_valid <= 1'b0;
      ctl_incr  <= 1'b0;
      ctl_decr  <= 1'b0;
    end else begin
      rx_strobe <= take;
      if (take) begin
        rx_data <= byte_buf;
      end
      if (fire) begin
        ctl_valid <= 1'b0;
        ctl_incr  <= 1'b0;
        ctl_decr  <= 1'b0;
      end else if (take && byte_buf == CMD_INCR) begin
        ctl_valid <= 1'b1;
        ctl_incr  <= 1'b1;
        ctl_decr  <= 1'b0;
      end else if (take && byte_buf == CMD_DECR) begin
        ctl_valid <= 1'b1;
        ctl_incr  <= 1'b0;
        ctl_decr  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_ctl_rx.sv
// tb/tb_uart_ctl_rx.sv - self-checking bench for uart_ctl_rx
module tb_uart_ctl_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       ctl_valid;
  logic       ctl_ready;
  logic       ctl_incr;
  logic       ctl_decr;

  uart_ctl_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .ctl_valid (ctl_valid),
    .ctl_ready (ctl_ready),
    .ctl_incr  (ctl_incr),
    .ctl_decr  (ctl_decr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int strobe_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  typedef struct {
    logic [7:0] data;
    logic       incr;
    logic       decr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rx_strobe) begin
      strobe_count++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got rx_data=%0h expected no strobe", rx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, exp_byte});
      end
    end
    if (ctl_incr && ctl_decr) begin
      checks++;
      $display("FAIL incr_decr_exclusive: got both 1 expected at most one");
    end
  end

  task automatic drive_bit(input logic v);
    @(posedge clk);
    #1 uart_rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    @(posedge clk);
    #1 uart_rx = 1'b1;
  endtask

  task automatic pulse_ready(input int n);
    @(posedge clk);
    #1 ctl_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 ctl_ready = 1'b0;
  endtask

  task automatic check_outputs(input string name, input logic [7:0] d, input logic s,
                               input logic v, input logic inc, input logic dec);
    check({name, "_rx_data"}, {24'd0, rx_data}, {24'd0, d});
    check({name, "_rx_strobe"}, {31'd0, rx_strobe}, {31'd0, s});
    check({name, "_ctl_valid"}, {31'd0, ctl_valid}, {31'd0, v});
    check({name, "_ctl_incr"}, {31'd0, ctl_incr}, {31'd0, inc});
    check({name, "_ctl_decr"}, {31'd0, ctl_decr}, {31'd0, dec});
  endtask

  initial begin
    int sc;
    int bad;
    logic [7:0] b;

    vecs[0] = '{8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'h31, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h32, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h30, 1'b0, 1'b0};
    vecs[6] = '{8'h33, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b0, 1'b0};

    // 1: reset held 5 clk, then idle line for 100 clk
    rst = 1'b1;
    uart_rx = 1'b1;
    ctl_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("idle_no_strobe", strobe_count, 0);
    check_outputs("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: table of single frames, each fully handshaken
    for (int i = 0; i < 8; i++) begin
      sc = strobe_count;
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("vec_strobe_count", strobe_count, sc + 1);
      check("vec_ctl_valid", {31'd0, ctl_valid}, {31'd0, vecs[i].incr | vecs[i].decr});
      check("vec_ctl_incr", {31'd0, ctl_incr}, {31'd0, vecs[i].incr});
      check("vec_ctl_decr", {31'd0, ctl_decr}, {31'd0, vecs[i].decr});
      if (vecs[i].incr || vecs[i].decr) begin
        pulse_ready(1);
        @(negedge clk);
        check("vec_cleared", {31'd0, ctl_valid}, 32'd0);
      end
    end
    check("vec_queue_empty", exp_q.size(), 0);

    // 3: increment held for 40 clk with ready low, then 2-clk ready pulse
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    repeat (3) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(ctl_valid && ctl_incr && !ctl_decr)) bad++;
    end
    check("incr_hold_40", bad, 0);
    @(posedge clk);
    #1 ctl_ready = 1'b1;
    @(negedge clk);
    check("incr_before_edge", {31'd0, ctl_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("incr_cleared_next_edge", {31'd0, ctl_valid}, 32'd0);
    check("incr_flag_cleared", {31'd0, ctl_incr}, 32'd0);
    @(posedge clk);
    #1 ctl_ready = 1'b0;
    @(negedge clk);
    check("ready_without_valid", {31'd0, ctl_valid}, 32'd0);

    // 4: pending decrement back-pressures; 0x0F buffered, 0x31 dropped
    sc = strobe_count;
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_outputs("decr", 8'h32, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    send_frame(8'h31, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_outputs("decr_held", 8'h32, 1'b0, 1'b1, 1'b0, 1'b1);
    check("bp_no_strobe", strobe_count, sc + 1);
    pulse_ready(1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_strobe_0f", strobe_count, sc + 2);
    check_outputs("after_bp", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_queue_empty", exp_q.size(), 0);

    // 5: 4-clk low glitch, framing error, then a good frame
    sc = strobe_count;
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_no_strobe", strobe_count, sc);
    send_frame(8'hA5, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("frame_err_no_strobe", strobe_count, sc);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("recover_strobe", strobe_count, sc + 1);
    check("recover_no_cmd", {31'd0, ctl_valid}, 32'd0);
    check("recover_queue_empty", exp_q.size(), 0);

    // 6: reset in the middle of bit 4 of a 0x31 frame
    sc = strobe_count;
    b = 8'h31;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    @(posedge clk);
    #1 uart_rx = b[4];
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check_outputs("midframe_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("abort_no_strobe", strobe_count, sc);
    check("abort_no_cmd", {31'd0, ctl_valid}, 32'd0);
    exp_q.push_back(8'h32);
    send_frame(8'h32, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst", 8'h32, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_ready(1);
    @(negedge clk);
    check("post_rst_cleared", {31'd0, ctl_valid}, 32'd0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
